// File: rtl/spi_sram_arbiter_pkg.sv
// spi_sram_arbiter_pkg: shared state encodings, port indices and 23LC1024 command codes
package spi_sram_arbiter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;
  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;
  localparam logic [7:0] CMD_READ = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_EQIO = 8'h38;
  localparam logic [7:0] CMD_RSTIO = 8'hFF;
  localparam logic [7:0] CMD_RDMR = 8'h05;
  localparam logic [7:0] CMD_WRMR = 8'h01;
  localparam logic [1:0] MODE_BYTE = 2'b00;
  localparam logic [1:0] MODE_PAGE = 2'b10;
  localparam logic [1:0] MODE_SEQ = 2'b01;
endpackage

// File: rtl/spi_sram_arbiter_if.sv
// spi_sram_arbiter_if: requester ports, encoder connection and status of the SRAM arbiter
// req/we/addr/wdata 0/1: requester inputs; ack/rdata 0/1: completion outputs; error: sticky timeout
// enc_request/address/write_enable/data_out: to encoder; enc_data_in/busy/initialized: from encoder
interface spi_sram_arbiter_if #(parameter int WORD_WIDTH = 16, parameter int ADDRESS_WIDTH = 16);
  logic req0, req1, we0, we1, ack0, ack1, error;
  logic [ADDRESS_WIDTH-1:0] addr0, addr1, enc_address;
  logic [WORD_WIDTH-1:0] wdata0, wdata1, rdata0, rdata1, enc_data_out, enc_data_in;
  logic enc_request, enc_write_enable, enc_busy, enc_initialized;
  modport slave (
    input req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, enc_data_in, enc_busy, enc_initialized,
    output ack0, ack1, rdata0, rdata1, error, enc_request, enc_address, enc_write_enable, enc_data_out
  );
  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, enc_data_in, enc_busy, enc_initialized,
    input ack0, ack1, rdata0, rdata1, error, enc_request, enc_address, enc_write_enable, enc_data_out
  );
endinterface

// File: rtl/spi_sram_arbiter_rr_arbiter2.sv
// rr_arbiter2: combinational two-request round-robin grant
// req0/req1: requests; last_grant: port granted previously; grant_valid/grant_idx: winner
module rr_arbiter2 (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_idx
);
  assign grant_valid = req0 | req1;
  assign grant_idx = (req0 & req1) ? ~last_grant : req1;
endmodule

// File: rtl/spi_sram_arbiter.sv
// spi_sram_arbiter: shares one quad-SPI SRAM encoder between two requesters with round-robin grant
// clk: system clock (encoder clock); reset_n: async active-low reset; bus: requester and encoder signals
import spi_sram_arbiter_pkg::*;
module spi_sram_arbiter #(
  parameter int WORD_WIDTH = 16,
  parameter int ADDRESS_WIDTH = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic clk,
  input logic reset_n,
  spi_sram_arbiter_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] T_MAX = CW'(TIMEOUT_CYCLES);
  state_t state, state_n;
  logic grant, last_grant, grant_valid, grant_idx, take, capture, abort, error;
  logic [CW-1:0] cnt;
  logic [ADDRESS_WIDTH-1:0] enc_address;
  logic enc_write_enable;
  logic [WORD_WIDTH-1:0] enc_data_out, rdata0, rdata1;
  rr_arbiter2 u_rr (
    .req0(bus.req0),
    .req1(bus.req1),
    .last_grant(last_grant),
    .grant_valid(grant_valid),
    .grant_idx(grant_idx)
  );
  // abort fires only when the normal exit of the state is not also happening
  always_comb begin
    take = state == IDLE && bus.enc_initialized && !bus.enc_busy && grant_valid;
    capture = state == WAIT && !bus.enc_busy;
    abort = cnt == T_MAX && ((state == ISSUE && !bus.enc_busy) || (state == WAIT && bus.enc_busy));
    state_n = state;
    case (state)
      IDLE: state_n = take ? ISSUE : IDLE;
      ISSUE: state_n = bus.enc_busy ? WAIT : abort ? DONE : ISSUE;
      WAIT: state_n = (capture || abort) ? DONE : WAIT;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant <= PORT0;
      last_grant <= PORT1;
      cnt <= '0;
      enc_address <= '0;
      enc_write_enable <= 1'b0;
      enc_data_out <= '0;
      rdata0 <= '0;
      rdata1 <= '0;
      error <= 1'b0;
    end else begin
      if (take) begin
        grant <= grant_idx;
        last_grant <= grant_idx;
        enc_address <= grant_idx ? bus.addr1 : bus.addr0;
        enc_write_enable <= grant_idx ? bus.we1 : bus.we0;
        enc_data_out <= grant_idx ? bus.wdata1 : bus.wdata0;
        cnt <= '0;
      end else if (state == ISSUE || state == WAIT) cnt <= cnt + 1'b1;
      if (abort) error <= 1'b1;
      if ((capture || abort) && !enc_write_enable) begin
        if (grant == PORT1) rdata1 <= capture ? bus.enc_data_in : '1;
        else rdata0 <= capture ? bus.enc_data_in : '1;
      end
    end
  end
  assign bus.enc_request = state == ISSUE;
  assign bus.enc_address = enc_address;
  assign bus.enc_write_enable = enc_write_enable;
  assign bus.enc_data_out = enc_data_out;
  assign bus.ack0 = state == DONE && grant == PORT0;
  assign bus.ack1 = state == DONE && grant == PORT1;
  assign bus.rdata0 = rdata0;
  assign bus.rdata1 = rdata1;
  assign bus.error = error;
endmodule

// File: tb/tb_spi_sram_arbiter.sv
// tb_spi_sram_arbiter: directed bench for spi_sram_arbiter with a behavioural encoder/SRAM model
module tb_spi_sram_arbiter;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;
  spi_sram_arbiter_if #(.WORD_WIDTH(16), .ADDRESS_WIDTH(16)) bus ();
  spi_sram_arbiter #(.WORD_WIDTH(16), .ADDRESS_WIDTH(16), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );
  int n_cmp = 0;
  int n_bad = 0;
  logic hang = 1'b0;
  logic phase;
  logic [3:0] mcnt;
  logic [15:0] m_addr;
  logic [15:0] mem [0:65535];
  // encoder model: accepts a request only on alternate clocks, busy for 7 clocks,
  // re-reads write_enable at completion; hang keeps busy high forever
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase <= 1'b0;
      bus.enc_busy <= 1'b0;
      bus.enc_data_in <= '0;
      mcnt <= '0;
      m_addr <= '0;
      mem[16'h1234] <= 16'hBEEF;
      mem[16'h0042] <= 16'h1111;
    end else begin
      phase <= ~phase;
      if (!bus.enc_busy) begin
        if (bus.enc_request && phase) begin
          bus.enc_busy <= 1'b1;
          mcnt <= 4'd6;
          m_addr <= bus.enc_address;
        end
      end else if (!hang) begin
        if (mcnt == 0) begin
          bus.enc_busy <= 1'b0;
          if (bus.enc_write_enable) mem[m_addr] <= bus.enc_data_out;
          else bus.enc_data_in <= mem[m_addr];
        end else mcnt <= mcnt - 1'b1;
      end
    end
  end
  task automatic do_txn(input bit p, input bit w, input logic [15:0] a, input logic [15:0] d,
                        output bit seen, output int lat, output int span, output bit stable,
                        output bit other, output bit single, output logic [15:0] ea,
                        output bit ew, output logic [15:0] ed);
    int t0, tf;
    bit started, pb;
    seen = 0; lat = -1; span = -1; stable = 1; other = 0; single = 0;
    started = 0; t0 = 0; tf = -100; ea = '0; ew = 0; ed = '0;
    if (p) begin bus.we1 = w; bus.addr1 = a; bus.wdata1 = d; bus.req1 = 1'b1; end
    else begin bus.we0 = w; bus.addr0 = a; bus.wdata0 = d; bus.req0 = 1'b1; end
    pb = bus.enc_busy;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (!started && bus.enc_request) begin
        started = 1; t0 = i; ea = bus.enc_address; ew = bus.enc_write_enable; ed = bus.enc_data_out;
      end else if (started && (bus.enc_address !== ea || bus.enc_write_enable !== ew || bus.enc_data_out !== ed))
        stable = 0;
      if (pb && !bus.enc_busy) tf = i;
      pb = bus.enc_busy;
      if (p ? bus.ack0 : bus.ack1) other = 1;
      if (p ? bus.ack1 : bus.ack0) begin seen = 1; lat = i - tf; span = i - t0; end
    end
    if (p) bus.req1 = 1'b0; else bus.req0 = 1'b0;
    @(negedge clk);
    single = !(p ? bus.ack1 : bus.ack0);
  endtask
  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if ({bus.ack0, bus.ack1} !== 2'b00) begin n_bad++; $display("FAIL reset_ack: got %b expected 00", {bus.ack0, bus.ack1}); end
    n_cmp++; if ({bus.enc_request, bus.enc_write_enable, bus.enc_address, bus.enc_data_out} !== 34'd0) begin n_bad++; $display("FAIL reset_enc: got %h expected 0", {bus.enc_request, bus.enc_write_enable, bus.enc_address, bus.enc_data_out}); end
    n_cmp++; if ({bus.rdata0, bus.rdata1, bus.error} !== 33'd0) begin n_bad++; $display("FAIL reset_rdata_err: got %h expected 0", {bus.rdata0, bus.rdata1, bus.error}); end
    reset_n = 1'b1;
  endtask
  task automatic test_init_gating;
    bit rq, got, seen;
    bus.enc_initialized = 1'b0; bus.addr0 = 16'h0042; bus.we0 = 1'b0; bus.req0 = 1'b1; rq = 0;
    repeat (6) begin @(negedge clk); rq |= bus.enc_request; end
    n_cmp++; if (rq !== 1'b0) begin n_bad++; $display("FAIL init_gate: enc_request got %b expected 0", rq); end
    bus.enc_initialized = 1'b1; got = 0;
    repeat (2) begin @(negedge clk); got |= bus.enc_request; end
    n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL init_release: enc_request got %b expected 1", got); end
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin @(negedge clk); seen = bus.ack0; end
    bus.req0 = 1'b0;
    n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL init_ack: got %b expected 1", seen); end
    n_cmp++; if (bus.rdata0 !== 16'h1111) begin n_bad++; $display("FAIL init_rdata0: got %h expected 1111", bus.rdata0); end
    @(negedge clk);
  endtask
  task automatic test_port0_read;
    bit seen, stable, other, single, ew; int lat, span; logic [15:0] ea, ed;
    do_txn(1'b0, 1'b0, 16'h1234, 16'h0000, seen, lat, span, stable, other, single, ea, ew, ed);
    n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL p0_ack: got %b expected 1", seen); end
    n_cmp++; if (lat != 1) begin n_bad++; $display("FAIL p0_ack_latency: got %0d expected 1", lat); end
    n_cmp++; if (single !== 1'b1) begin n_bad++; $display("FAIL p0_ack_single: got %b expected 1", single); end
    n_cmp++; if (bus.rdata0 !== 16'hBEEF) begin n_bad++; $display("FAIL p0_rdata: got %h expected beef", bus.rdata0); end
    n_cmp++; if (other !== 1'b0) begin n_bad++; $display("FAIL p0_ack1: got %b expected 0", other); end
    n_cmp++; if ({ea, ew} !== {16'h1234, 1'b0}) begin n_bad++; $display("FAIL p0_enc: got %h/%b expected 1234/0", ea, ew); end
  endtask
  task automatic test_port1_write;
    bit seen, stable, other, single, ew; int lat, span; logic [15:0] ea, ed;
    do_txn(1'b1, 1'b1, 16'hAED0, 16'hCAFE, seen, lat, span, stable, other, single, ea, ew, ed);
    n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL p1w_ack: got %b expected 1", seen); end
    n_cmp++; if ({ea, ew, ed} !== {16'hAED0, 1'b1, 16'hCAFE}) begin n_bad++; $display("FAIL p1w_enc: got %h/%b/%h expected aed0/1/cafe", ea, ew, ed); end
    n_cmp++; if (stable !== 1'b1) begin n_bad++; $display("FAIL p1w_stable: got %b expected 1", stable); end
    n_cmp++; if (mem[16'hAED0] !== 16'hCAFE) begin n_bad++; $display("FAIL p1w_mem: got %h expected cafe", mem[16'hAED0]); end
    n_cmp++; if (bus.rdata1 !== 16'h0000) begin n_bad++; $display("FAIL p1w_rdata1: got %h expected 0000", bus.rdata1); end
    n_cmp++; if (other !== 1'b0) begin n_bad++; $display("FAIL p1w_ack0: got %b expected 0", other); end
  endtask
  task automatic test_contention;
    int k; bit overlap; logic [3:0] seq;
    k = 0; overlap = 0; seq = '0;
    bus.addr0 = 16'h1234; bus.we0 = 1'b0; bus.addr1 = 16'hAED0; bus.we1 = 1'b0;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    for (int i = 0; i < 400 && k < 4; i++) begin
      @(negedge clk);
      if (bus.ack0 && bus.ack1) overlap = 1;
      if (bus.ack0 || bus.ack1) begin seq[k] = bus.ack1; k++; end
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    @(negedge clk);
    n_cmp++; if (k != 4) begin n_bad++; $display("FAIL cont_count: got %0d expected 4", k); end
    n_cmp++; if (seq !== 4'b1010) begin n_bad++; $display("FAIL cont_order: got %b expected 1010 (bit0 first)", seq); end
    n_cmp++; if (overlap !== 1'b0) begin n_bad++; $display("FAIL cont_overlap: got %b expected 0", overlap); end
    n_cmp++; if ({bus.rdata0, bus.rdata1} !== {16'hBEEF, 16'hCAFE}) begin n_bad++; $display("FAIL cont_rdata: got %h/%h expected beef/cafe", bus.rdata0, bus.rdata1); end
  endtask
  task automatic test_timeout;
    bit seen, stable, other, single, ew, held; int lat, span; logic [15:0] ea, ed;
    hang = 1'b1;
    do_txn(1'b0, 1'b0, 16'h0055, 16'h0000, seen, lat, span, stable, other, single, ea, ew, ed);
    n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL to_ack: got %b expected 1", seen); end
    n_cmp++; if (span != 17) begin n_bad++; $display("FAIL to_span: got %0d expected 17", span); end
    n_cmp++; if (bus.rdata0 !== 16'hFFFF) begin n_bad++; $display("FAIL to_rdata: got %h expected ffff", bus.rdata0); end
    n_cmp++; if (bus.error !== 1'b1) begin n_bad++; $display("FAIL to_error: got %b expected 1", bus.error); end
    held = 1;
    repeat (5) begin @(negedge clk); held &= bus.error; end
    n_cmp++; if (held !== 1'b1) begin n_bad++; $display("FAIL to_sticky: got %b expected 1", held); end
    reset_n = 1'b0; hang = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.error !== 1'b0) begin n_bad++; $display("FAIL to_clear: got %b expected 0", bus.error); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_reset_midop;
    bit inw, anyack, rq, seen, stable, other, single, ew; int lat, span; logic [15:0] ea, ed;
    bus.enc_initialized = 1'b1; bus.addr1 = 16'h1234; bus.we1 = 1'b0; bus.req1 = 1'b1; inw = 0;
    for (int i = 0; i < 60 && !inw; i++) begin @(negedge clk); inw = bus.enc_busy && !bus.enc_request; end
    n_cmp++; if (inw !== 1'b1) begin n_bad++; $display("FAIL mid_wait: got %b expected 1", inw); end
    #2 reset_n = 1'b0; bus.enc_initialized = 1'b0; bus.req1 = 1'b0;
    #1;
    n_cmp++; if ({bus.ack0, bus.ack1, bus.enc_request} !== 3'b000) begin n_bad++; $display("FAIL mid_ack_req: got %b expected 000", {bus.ack0, bus.ack1, bus.enc_request}); end
    n_cmp++; if ({bus.enc_address, bus.rdata1} !== 32'd0) begin n_bad++; $display("FAIL mid_regs: got %h expected 0", {bus.enc_address, bus.rdata1}); end
    anyack = 0;
    repeat (3) begin @(negedge clk); anyack |= bus.ack0 | bus.ack1; end
    reset_n = 1'b1; rq = 0;
    repeat (4) begin @(negedge clk); anyack |= bus.ack0 | bus.ack1; rq |= bus.enc_request; end
    n_cmp++; if ({anyack, rq} !== 2'b00) begin n_bad++; $display("FAIL mid_quiet: ack/req got %b expected 00", {anyack, rq}); end
    bus.enc_initialized = 1'b1;
    do_txn(1'b1, 1'b0, 16'h1234, 16'h0000, seen, lat, span, stable, other, single, ea, ew, ed);
    n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL mid_after_ack: got %b expected 1", seen); end
    n_cmp++; if (bus.rdata1 !== 16'hBEEF) begin n_bad++; $display("FAIL mid_after_rdata: got %h expected beef", bus.rdata1); end
    n_cmp++; if (lat != 1) begin n_bad++; $display("FAIL mid_after_latency: got %0d expected 1", lat); end
  endtask
  initial begin
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.we0 = 1'b0; bus.we1 = 1'b0;
    bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
    bus.enc_initialized = 1'b0;
    test_reset;
    test_init_gating;
    test_port0_read;
    test_port1_write;
    test_contention;
    test_timeout;
    test_reset_midop;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
